// File: rtl/usb_burst_rd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : usb_burst_rd_ctrl                                         |
// | Brief    : FX3 slave-FIFO burst read sequencer. Waits for FLAGA and   |
// |            a free cache slot, reads BURST_LEN words, hides the FIFO   |
// |            read latency and ends each burst with frame_done/err.      |
// | Options  : define TRAILER_CHECK_EN to compare the word written at     |
// |            the last address against TRAILER (mismatch -> frame_err).  |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module usb_burst_rd_ctrl #(
  parameter int          BURST_LEN   = 256,
  parameter int          RD_LATENCY  = 2,
  parameter int          FLAG_SETTLE = 2,
  parameter logic [31:0] TRAILER     = 32'hFFAA00AA
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         USB3_FLAGA,
  input  logic [31:0]                  USB3_DATA,
  input  logic                         buf_ready,
  output logic                         SLRD_n,
  output logic                         SLOE_n,
  output logic [3:0]                   usb_rd_state,
  output logic                         wr_en,
  output logic [$clog2(BURST_LEN)-1:0] wr_addr,
  output logic [31:0]                  wr_data,
  output logic                         frame_done,
  output logic                         frame_err
);

  localparam int c_AW = $clog2(BURST_LEN);
  localparam int c_CW = c_AW + 1;

  localparam logic [3:0] c_IDLE   = 4'd0;
  localparam logic [3:0] c_SETTLE = 4'd3;
  localparam logic [3:0] c_READ   = 4'd6;
  localparam logic [3:0] c_DRAIN  = 4'd7;
  localparam logic [3:0] c_DONE   = 4'd8;

  localparam logic [3:0]      c_SETTLE_LAST = 4'(FLAG_SETTLE - 1);
  localparam logic [2:0]      c_DRAIN_LAST  = 3'(RD_LATENCY - 1);
  localparam logic [c_CW-1:0] c_BURST       = c_CW'(BURST_LEN);
  localparam logic [c_AW-1:0] c_LAST_ADDR   = c_AW'(BURST_LEN - 1);

  logic [3:0]            r_state;
  logic [3:0]            w_state_nxt;
  logic [3:0]            r_settle_cnt;
  logic [c_CW-1:0]       r_issue_cnt;
  logic [2:0]            r_drain_cnt;
  logic [c_AW-1:0]       r_cap_cnt;
  logic                  r_cap_wrap;
  logic                  r_abort;
  logic [RD_LATENCY-1:0] r_pipe;

  logic w_start;
  logic w_abort_set;
  logic w_issue;
  logic w_capture;
  logic w_count_ok;
  logic w_trl_bad;
  logic w_slrd_n_nxt;
  logic w_sloe_n_nxt;
  logic w_done_nxt;
  logic w_err_nxt;

  assign usb_rd_state = r_state;
  assign w_start      = (r_state == c_IDLE) && (w_state_nxt == c_SETTLE);
  assign w_capture    = r_pipe[RD_LATENCY-1];
  // A full burst leaves the wrapping capture counter back at zero after a wrap.
  assign w_count_ok   = r_cap_wrap && (r_cap_cnt == '0);

  // Next-state decision; a FLAGA drop in READ wins over burst completion.
  always_comb begin
    w_state_nxt = r_state;
    w_abort_set = 1'b0;
    case (r_state)
      c_IDLE:   if (USB3_FLAGA && buf_ready) w_state_nxt = c_SETTLE;
      c_SETTLE: begin
        if (!USB3_FLAGA)                       w_state_nxt = c_IDLE;
        else if (r_settle_cnt == c_SETTLE_LAST) w_state_nxt = c_READ;
      end
      c_READ: begin
        if (!USB3_FLAGA) begin
          w_state_nxt = c_DRAIN;
          w_abort_set = 1'b1;
        end else if (r_issue_cnt == c_BURST) begin
          w_state_nxt = c_DRAIN;
        end
      end
      c_DRAIN:  if (r_drain_cnt == c_DRAIN_LAST) w_state_nxt = c_DONE;
      c_DONE:   w_state_nxt = c_IDLE;
      default:  w_state_nxt = c_IDLE;
    endcase
  end

  // Output decode from the next state so every pin is a plain flop.
  always_comb begin
    w_issue      = (w_state_nxt == c_READ);
    w_slrd_n_nxt = ~w_issue;
    w_sloe_n_nxt = ~((w_state_nxt == c_READ) || (w_state_nxt == c_DRAIN));
    w_done_nxt   = (w_state_nxt == c_DONE);
    w_err_nxt    = w_done_nxt && (r_abort || !w_count_ok || w_trl_bad);
  end

  // State register, FX3 strobes, burst report and sequencing counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= c_IDLE;
      SLRD_n       <= 1'b1;
      SLOE_n       <= 1'b1;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
      r_settle_cnt <= '0;
      r_issue_cnt  <= '0;
      r_drain_cnt  <= '0;
      r_abort      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      SLRD_n     <= w_slrd_n_nxt;
      SLOE_n     <= w_sloe_n_nxt;
      frame_done <= w_done_nxt;
      frame_err  <= w_err_nxt;
      if (w_start) begin
        r_settle_cnt <= '0;
        r_issue_cnt  <= '0;
        r_abort      <= 1'b0;
      end else begin
        if (r_state == c_SETTLE) r_settle_cnt <= r_settle_cnt + 4'd1;
        if (w_issue)             r_issue_cnt  <= r_issue_cnt + c_CW'(1);
        if (w_abort_set)         r_abort      <= 1'b1;
      end
      r_drain_cnt <= (r_state == c_DRAIN) ? r_drain_cnt + 3'd1 : 3'd0;
    end
  end

  // Capture stage: write the bus word when the latency pipe says it is valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      r_cap_cnt  <= '0;
      r_cap_wrap <= 1'b0;
    end else begin
      wr_en <= w_capture;
      if (w_start) begin
        r_cap_cnt  <= '0;
        r_cap_wrap <= 1'b0;
      end else if (w_capture) begin
        wr_addr   <= r_cap_cnt;
        wr_data   <= USB3_DATA;
        r_cap_cnt <= r_cap_cnt + c_AW'(1);
        if (r_cap_cnt == c_LAST_ADDR) r_cap_wrap <= 1'b1;
      end
    end
  end

  generate
    if (RD_LATENCY == 1) begin : g_pipe_single
      // Single-stage read tracker.
      always_ff @(posedge clk) begin
        if (!rst_n) r_pipe <= '0;
        else        r_pipe <= w_issue;
      end
    end else begin : g_pipe_shift
      // Shift register delaying each issued read by the FIFO latency.
      always_ff @(posedge clk) begin
        if (!rst_n) r_pipe <= '0;
        else        r_pipe <= {r_pipe[RD_LATENCY-2:0], w_issue};
      end
    end
  endgenerate

`ifdef TRAILER_CHECK_EN
  logic r_trl_bad;

  // Remember whether the word at the final address matched the trailer.
  always_ff @(posedge clk) begin
    if (!rst_n)        r_trl_bad <= 1'b0;
    else if (w_start)  r_trl_bad <= 1'b0;
    else if (w_capture && (r_cap_cnt == c_LAST_ADDR))
      r_trl_bad <= (USB3_DATA != TRAILER);
  end

  assign w_trl_bad = r_trl_bad;
`else
  assign w_trl_bad = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_usb_burst_rd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_usb_burst_rd_ctrl                                      |
// | Brief    : Self-checking bench for usb_burst_rd_ctrl with an FX3     |
// |            FIFO model, a vector table and randomized bursts.         |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_usb_burst_rd_ctrl;

  localparam int          BL  = 256;
  localparam int          RL  = 2;
  localparam int          FS  = 2;
  localparam logic [31:0] TRL = 32'hFFAA00AA;
`ifdef TRAILER_CHECK_EN
  localparam bit c_TRL_ON = 1'b1;
`else
  localparam bit c_TRL_ON = 1'b0;
`endif

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        fl_req    = 1'b0;
  logic        fl_drop   = 1'b0;
  logic        buf_ready = 1'b0;
  logic [31:0] USB3_DATA = '0;
  logic        USB3_FLAGA;
  logic        SLRD_n, SLOE_n, wr_en, frame_done, frame_err;
  logic [3:0]  usb_rd_state;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;

  assign USB3_FLAGA = fl_req & ~fl_drop;

  usb_burst_rd_ctrl #(
    .BURST_LEN  (BL),
    .RD_LATENCY (RL),
    .FLAG_SETTLE(FS),
    .TRAILER    (TRL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .USB3_FLAGA  (USB3_FLAGA),
    .USB3_DATA   (USB3_DATA),
    .buf_ready   (buf_ready),
    .SLRD_n      (SLRD_n),
    .SLOE_n      (SLOE_n),
    .usb_rd_state(usb_rd_state),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_done  (frame_done),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Scenario handshake and FX3 / cache observation state.
  int          sc_id    = 0;
  int          mon_id   = 0;
  int          sc_abort = -1;
  logic [31:0] burst_data [BL];
  int          fx_rd_cnt = 0;
  int          rd_hist [4] = '{-1, -1, -1, -1};
  int          cap_n    = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  bit          done_err = 1'b0;
  logic [7:0]  cap_addr [BL];
  logic [31:0] cap_data [BL];

  // FX3 FIFO model and cache-side monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    if (sc_id != mon_id) begin
      mon_id    = sc_id;
      fx_rd_cnt = 0;
      cap_n     = 0;
      done_cnt  = 0;
      fl_drop   = 1'b0;
      for (int i = 0; i < 4; i++) rd_hist[i] = -1;
    end
    if (wr_en === 1'b1) begin
      if (cap_n < BL) begin
        cap_addr[cap_n] = wr_addr;
        cap_data[cap_n] = wr_data;
      end
      cap_n++;
    end
    if (frame_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = frame_err;
    end
    for (int i = 3; i > 0; i--) rd_hist[i] = rd_hist[i-1];
    if (SLRD_n === 1'b0) begin
      rd_hist[0] = fx_rd_cnt;
      fx_rd_cnt++;
    end else begin
      rd_hist[0] = -1;
    end
    if (sc_abort > 0 && fx_rd_cnt == sc_abort) fl_drop = 1'b1;
    USB3_DATA = (rd_hist[RL-1] >= 0) ? burst_data[rd_hist[RL-1] % BL] : $urandom;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected outcome of one burst from the read/abort rules alone.
  function automatic void model(input int abort_at, output int n, output bit err, output int lat);
    n   = (abort_at < 0) ? BL : abort_at;
    err = (abort_at >= 0) || (n != BL) || (c_TRL_ON && (burst_data[BL-1] != TRL));
    lat = 1 + FS + n + RL + 1;
  endfunction

  task automatic finish_burst(input string tag, input int t0, input bit drop_br,
                              input int exp_n, input bit exp_err, input int exp_lat);
    int w = 0;
    while (done_cnt == 0 && w < 4000) begin
      @(posedge clk); #2;
      w++;
      if (drop_br && w == 10) buf_ready = 1'b0;
    end
    fl_req = 1'b0;
    chk({tag, " done_seen"}, longint'(done_cnt != 0), 1);
    repeat (RL + 4) @(posedge clk);
    #2;
    chk({tag, " done_pulses"}, done_cnt, 1);
    chk({tag, " latency"}, done_cyc - t0 + 1, exp_lat);
    chk({tag, " frame_err"}, done_err, exp_err);
    chk({tag, " words"}, cap_n, exp_n);
    chk({tag, " reads"}, fx_rd_cnt, exp_n);
    for (int i = 0; i < BL && i < cap_n && i < exp_n; i++) begin
      chk({tag, $sformatf(" addr[%0d]", i)}, cap_addr[i], i);
      chk({tag, $sformatf(" data[%0d]", i)}, cap_data[i], burst_data[i]);
    end
    chk({tag, " back_idle"}, usb_rd_state, 0);
  endtask

  task automatic run_burst(input string tag, input int abort_at, input int br_delay,
                           input bit drop_br, input int exp_n, input bit exp_err, input int exp_lat);
    int t0;
    sc_abort = abort_at;
    sc_id++;
    @(posedge clk); #2;
    fl_req    = 1'b1;
    buf_ready = 1'b0;
    for (int i = 0; i < br_delay; i++) begin
      @(posedge clk); #2;
      chk({tag, " idle_hold"}, usb_rd_state, 0);
    end
    buf_ready = 1'b1;
    t0 = cyc;
    finish_burst(tag, t0, drop_br, exp_n, exp_err, exp_lat);
  endtask

  typedef struct {
    int          abort_at;
    logic [31:0] last_word;
    int          br_delay;
    int          exp_n;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int t0;
    int w;

    vecs[0] = '{-1,  TRL,          0, 256, 1'b0,     262};
    vecs[1] = '{-1,  32'h000000FF, 0, 256, c_TRL_ON, 262};
    vecs[2] = '{100, TRL,          0, 100, 1'b1,     106};
    vecs[3] = '{256, TRL,          0, 256, 1'b1,     262};
    vecs[4] = '{-1,  TRL,          6, 256, 1'b0,     262};
    vecs[5] = '{1,   TRL,          0, 1,   1'b1,     7};

    // Reset values.
    repeat (3) @(posedge clk);
    #2;
    chk("rst SLRD_n", SLRD_n, 1);
    chk("rst SLOE_n", SLOE_n, 1);
    chk("rst state", usb_rd_state, 0);
    chk("rst wr_en", wr_en, 0);
    chk("rst wr_addr", wr_addr, 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst frame_err", frame_err, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // FLAGA for a single cycle: SETTLE gives up without reading.
    sc_abort = -1;
    sc_id++;
    @(posedge clk); #2;
    buf_ready = 1'b1;
    fl_req    = 1'b1;
    @(posedge clk); #2;
    chk("settle state", usb_rd_state, 3);
    fl_req = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    chk("settle reads", fx_rd_cnt, 0);
    chk("settle done", done_cnt, 0);
    chk("settle idle", usb_rd_state, 0);

    // Vector table.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < BL; i++) burst_data[i] = i;
      burst_data[BL-1] = vecs[v].last_word;
      run_burst($sformatf("vec%0d", v), vecs[v].abort_at, vecs[v].br_delay, 1'b0,
                vecs[v].exp_n, vecs[v].exp_err, vecs[v].exp_lat);
    end

    // Randomized bursts against the reference model.
    for (int k = 0; k < 6; k++) begin
      int ab;
      int n;
      bit e;
      int lat;
      ab = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, BL));
      for (int i = 0; i < BL; i++) burst_data[i] = $urandom;
      if ($urandom_range(0, 1) == 1) burst_data[BL-1] = TRL;
      model(ab, n, e, lat);
      run_burst($sformatf("rand%0d", k), ab, int'($urandom_range(0, 3)),
                bit'($urandom_range(0, 1)), n, e, lat);
    end

    // Reset in the middle of a burst, then a clean burst afterwards.
    for (int i = 0; i < BL; i++) burst_data[i] = i;
    burst_data[BL-1] = TRL;
    sc_abort = -1;
    sc_id++;
    @(posedge clk); #2;
    buf_ready = 1'b1;
    fl_req    = 1'b1;
    w = 0;
    while (fx_rd_cnt < 50 && w < 400) begin
      @(posedge clk); #2;
      w++;
    end
    chk("midrst reached", longint'(fx_rd_cnt >= 50), 1);
    rst_n = 1'b0;
    @(posedge clk); #2;
    chk("midrst SLRD_n", SLRD_n, 1);
    chk("midrst SLOE_n", SLOE_n, 1);
    chk("midrst wr_en", wr_en, 0);
    chk("midrst state", usb_rd_state, 0);
    chk("midrst frame_done", frame_done, 0);
    repeat (4) @(posedge clk);
    #2;
    chk("midrst no_done", done_cnt, 0);
    sc_id++;
    @(posedge clk); #2;
    rst_n = 1'b1;
    t0 = cyc;
    finish_burst("after_rst", t0, 1'b0, BL, c_TRL_ON && (burst_data[BL-1] != TRL), 262);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
